pipe_ex_recover: RTL

//  Inverse of the 3-stage A+B+(C-D)+D adder pipeline: takes a result word F plus operands A,B,D
//  and recovers C = F - A - B (mod 2^N) through a mirrored 3-stage elastic pipeline.

---
 rtl/pipe_ex_recover.sv | 93 +++++++++
 1 files changed

// File: rtl/pipe_ex_recover.sv
// Recovers C = F - A - B (mod 2^N) through a 3-stage elastic pipeline
// with valid/ready handshakes on both ends and a completed-transaction counter.
module pipe_ex_recover #(
  parameter int N     = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     F,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic [N-1:0]     D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     C,
  output logic [CNT_W-1:0] txn_cnt
);

  logic             v1_q, v2_q, v3_q;
  logic             v1_d, v2_d, v3_d;
  logic [N-1:0]     x1_q, y_q, d1_q, x3_q, d2_q, c_q;
  logic [N-1:0]     x1_d, y_d, d1_d, x3_d, d2_d, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en1, en2, en3;

  // Enables resolve from the output back so an empty stage always fills.
  assign en3      = !v3_q || out_ready;
  assign en2      = !v2_q || en3;
  assign en1      = !v1_q || en2;
  assign in_ready = en1 && !rst;

  always_comb begin
    v1_d  = v1_q;
    x1_d  = x1_q;
    y_d   = y_q;
    d1_d  = d1_q;
    v2_d  = v2_q;
    x3_d  = x3_q;
    d2_d  = d2_q;
    v3_d  = v3_q;
    c_d   = c_q;
    cnt_d = cnt_q;
    if (en1) begin
      v1_d = in_valid;
      x1_d = A + B;
      y_d  = F - D;
      d1_d = D;
    end
    if (en2) begin
      v2_d = v1_q;
      x3_d = y_q - x1_q;
      d2_d = d1_q;
    end
    if (en3) begin
      v3_d = v2_q;
      c_d  = x3_q + d2_q;
    end
    if (v3_q && out_ready) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      x1_q  <= '0;
      y_q   <= '0;
      d1_q  <= '0;
      x3_q  <= '0;
      d2_q  <= '0;
      c_q   <= '0;
      cnt_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      x1_q  <= x1_d;
      y_q   <= y_d;
      d1_q  <= d1_d;
      x3_q  <= x3_d;
      d2_q  <= d2_d;
      c_q   <= c_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = v3_q;
  assign C         = c_q;
  assign txn_cnt   = cnt_q;

endmodule
